par2ser: RTL and testbench
==========================

PAR2SER -- requirements
Module: par2ser

Interface
REQ-001 The block SHALL have parameter LENGTH, default 8, meaning parallel word width in bits; legal range LENGTH >= 2.
REQ-002 The block SHALL have port clock, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, meaning asynchronous active-high reset.
REQ-004 The block SHALL have port direct, input, 1 bit, meaning shift order: 0 = LSB first, 1 = MSB first; it is sampled with the word.
REQ-005 The block SHALL have port ivalid, input, 1 bit, meaning the upstream parallel word is valid.
REQ-006 The block SHALL have port iready, output, 1 bit, meaning the block accepts a word this cycle.
REQ-007 The block SHALL have port idata, input, LENGTH bits, meaning the parallel word.
REQ-008 The block SHALL have port ovalid, output, 1 bit, meaning odata carries a serial bit this cycle.
REQ-009 The block SHALL have port odata, output, 1 bit, meaning the serial data bit.
REQ-010 The block SHALL have port olast, output, 1 bit, meaning this is the final bit of the current frame.

Function
REQ-011 A word SHALL be accepted on a rising edge where ivalid && iready; there is no other transfer condition.
REQ-012 Upstream SHALL hold ivalid, idata and direct stable until acceptance; the block does not check this.
REQ-013 The control FSM SHALL have two states. IDLE: no frame active. SHIFT: a frame is being emitted.
REQ-014 iready SHALL be combinational: 1 in IDLE; 1 in SHIFT only on the cycle the last bit of the frame is presented (olast = 1); 0 otherwise.
REQ-015 On acceptance the block SHALL load a shift register with idata, latch direct, clear the bit counter and enter or stay in SHIFT.
REQ-016 The first serial bit SHALL appear on odata, with ovalid = 1, in the cycle after acceptance; latency is 1 clock.
REQ-017 With direct = 0 the bits SHALL be emitted idata[0] first and idata[LENGTH-1] last; with direct = 1 the order is reversed.
REQ-018 ovalid SHALL remain 1 for exactly one cycle per frame bit, with no gaps inside a frame.
REQ-019 olast SHALL be 1 only with the final bit of a frame, and only while ovalid = 1.
REQ-020 If a word is accepted in the olast cycle, its first bit SHALL follow in the very next cycle, giving seamless back-to-back frames.
REQ-021 If no word is accepted in the olast cycle, the FSM SHALL return to IDLE, and ovalid, olast and odata SHALL be 0 in the next cycle.
REQ-022 The bit counter SHALL be sized $clog2(frame length + 1) and SHALL NOT wrap within a frame.
REQ-023 odata, ovalid and olast SHALL be driven from registers.

Reset
REQ-024 While reset = 1, odata, ovalid and olast SHALL be 0, the FSM SHALL be in IDLE, and iready SHALL be 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, with no olast; after release the block SHALL be in IDLE with iready = 1.

Configuration
REQ-026 With macro PAR2SER_PARITY_EN defined, each frame SHALL be LENGTH+1 bits: the data bits followed by one even-parity bit (^idata), and olast SHALL mark the parity bit.
REQ-027 Without PAR2SER_PARITY_EN, frames SHALL be exactly LENGTH bits and no parity logic SHALL exist.

Structure
REQ-028 A shared package ser_pkg SHALL hold the FSM state encoding (ST_IDLE, ST_SHIFT) and the direction constants (DIR_LSB_FIRST = 0, DIR_MSB_FIRST = 1), for reuse by ser2par-side logic.
REQ-029 par2ser SHALL be a single module with no sub-modules; the shift register, counter and FSM are too small to justify separate modules.

Verification (LENGTH = 8)
REQ-030 Single word: idata = 8'hD5 with direct = 0, accepted at cycle 0 -> odata = 1,0,1,0,1,0,1,1 in cycles 1-8, olast only at cycle 8, ovalid = 0 at cycle 9.
REQ-031 Direction: idata = 8'hD5 with direct = 1 -> odata = 1,1,0,1,0,1,0,1 in cycles 1-8.
REQ-032 Back-to-back: ivalid held high with 8'hA5 then 8'h3C -> 16 consecutive ovalid cycles, iready high only in cycles 0 and 8, olast at cycles 8 and 16.
REQ-033 Loopback: par2ser output drives ser2par (ivalid = ovalid, idata = odata), with the same direct and random words -> ser2par odata equals each sent word.
REQ-034 Reset at cycle 4 of a frame -> outputs 0 immediately, no olast; the next word after release is emitted correctly from bit 0.
REQ-035 With PAR2SER_PARITY_EN and idata = 8'h07 -> 9 bits, 9th bit = 1, olast on the 9th bit.

Source files
------------

// File: rtl/ser_pkg.sv
// ser_pkg: shared serializer definitions (FSM states, shift-order constants)
// used by par2ser and the ser2par-side logic.
package ser_pkg;
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;
    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;
endpackage

// File: rtl/par2ser.sv
// par2ser: parallel word in (valid/ready) to framed serial bit stream out.
// Defining PAR2SER_PARITY_EN appends one even-parity bit to every frame.
module par2ser
    import ser_pkg::*;
#(
    parameter int LENGTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              direct,
    input  logic              ivalid,
    output logic              iready,
    input  logic [LENGTH-1:0] idata,
    output logic              ovalid,
    output logic              odata,
    output logic              olast
);
`ifdef PAR2SER_PARITY_EN
    localparam int FRAME = LENGTH + 1;
`else
    localparam int FRAME = LENGTH;
`endif
    localparam int CW = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

    state_t            r_state, w_state_nxt;
    logic [LENGTH-1:0] r_shift;
    logic              r_dir;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic              r_odata, r_ovalid, r_olast;
    logic              w_accept, w_bit_nxt;
`ifdef PAR2SER_PARITY_EN
    localparam logic [CW-1:0] PAR_IDX = CW'(LENGTH);
    logic              r_par;
`endif

    assign iready = !reset && (r_state == ST_IDLE || r_olast);
    assign ovalid = r_ovalid;
    assign odata  = r_odata;
    assign olast  = r_olast;

    always_comb begin
        w_accept    = ivalid && iready;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_bit_nxt   = (r_dir == DIR_MSB_FIRST) ? r_shift[LENGTH-1] : r_shift[0];
`ifdef PAR2SER_PARITY_EN
        w_bit_nxt   = (w_cnt_nxt == PAR_IDX) ? r_par : w_bit_nxt;
`endif
        w_state_nxt = w_accept ? ST_SHIFT : (r_olast ? ST_IDLE : r_state);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // The first bit is registered straight from idata so it appears one cycle after acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift  <= '0;
            r_dir    <= DIR_LSB_FIRST;
            r_cnt    <= '0;
            r_odata  <= 1'b0;
            r_ovalid <= 1'b0;
            r_olast  <= 1'b0;
`ifdef PAR2SER_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_shift  <= (direct == DIR_MSB_FIRST) ? idata << 1 : idata >> 1;
            r_dir    <= direct;
            r_cnt    <= '0;
            r_odata  <= (direct == DIR_MSB_FIRST) ? idata[LENGTH-1] : idata[0];
            r_ovalid <= 1'b1;
            r_olast  <= 1'b0;
`ifdef PAR2SER_PARITY_EN
            r_par    <= ^idata;
`endif
        end else if (r_olast) begin
            r_cnt    <= '0;
            r_odata  <= 1'b0;
            r_ovalid <= 1'b0;
            r_olast  <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            r_shift  <= (r_dir == DIR_MSB_FIRST) ? r_shift << 1 : r_shift >> 1;
            r_cnt    <= w_cnt_nxt;
            r_odata  <= w_bit_nxt;
            r_olast  <= (w_cnt_nxt == LAST_IDX);
        end
    end
endmodule

// File: tb/tb_par2ser.sv
// tb_par2ser: randomized bench for par2ser against a frame-queue reference model
// plus a behavioural deserializer fed by the DUT output (loopback).
module tb_par2ser;
`ifdef PAR2SER_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       direct = 1'b0;
    logic       ivalid = 1'b0;
    logic       iready;
    logic [7:0] idata = '0;
    logic       ovalid, odata, olast;

    par2ser #(.LENGTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .direct(direct),
        .ivalid(ivalid),
        .iready(iready),
        .idata (idata),
        .ovalid(ovalid),
        .odata (odata),
        .olast (olast)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bits still to be presented, and the bit presented now.
    logic [1:0] q[$];
    logic       cur_v = 0, cur_b = 0, cur_l = 0;
    // Loopback deserializer state.
    logic [8:0] sent[$];
    logic       rx_bits[FRAME];
    int         rx_n = 0;
    logic [15:0] obs = '0;
    int          ov_cnt = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] w, input logic d);
        for (int i = 0; i < 8; i++)
            q.push_back({FRAME == 8 && i == 7, d ? w[7 - i] : w[i]});
        if (FRAME == 9) q.push_back({1'b1, ^w});
        sent.push_back({d, w});
    endtask

    task automatic rx_take();
        logic [8:0] s;
        logic [7:0] w;
        if (!ovalid) return;
        if (rx_n < FRAME) rx_bits[rx_n] = odata;
        rx_n++;
        if (!olast) return;
        chk("rx_len", 16'(rx_n), 16'(FRAME));
        if (sent.size() == 0) begin
            chk("rx_extra_frame", 16'(1), 16'(0));
        end else begin
            s = sent.pop_front();
            w = '0;
            for (int i = 0; i < 8; i++) w[s[8] ? 7 - i : i] = rx_bits[i];
            chk("loopback_word", {8'h0, w}, {8'h0, s[7:0]});
            if (FRAME == 9) chk("loopback_parity", {15'h0, rx_bits[8]}, {15'h0, ^s[7:0]});
        end
        rx_n = 0;
    endtask

    // Starts at posedge+1 (or later, before the next negedge); ends at posedge+1.
    task automatic step(input logic v, input logic d, input logic [7:0] w);
        logic exp_rdy, acc;
        logic [1:0] e;
        ivalid = v; direct = d; idata = w;
        #2;
        exp_rdy = !cur_v || cur_l;
        chk("iready", {15'h0, iready}, {15'h0, exp_rdy});
        acc = v && exp_rdy;
        @(posedge clock);
        if (acc) push_frame(w, d);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            cur_v = 1; cur_b = e[0]; cur_l = e[1];
        end else begin
            cur_v = 0; cur_b = 0; cur_l = 0;
        end
        chk("ovalid", {15'h0, ovalid}, {15'h0, cur_v});
        chk("odata", {15'h0, odata}, {15'h0, cur_b});
        chk("olast", {15'h0, olast}, {15'h0, cur_l});
        obs = {obs[14:0], odata};
        ov_cnt = ovalid ? ov_cnt + 1 : 0;
        rx_take();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ivalid = 1'b0;
        #1;
        chk("rst_ovalid", {15'h0, ovalid}, 16'h0);
        chk("rst_olast", {15'h0, olast}, 16'h0);
        chk("rst_odata", {15'h0, odata}, 16'h0);
        chk("rst_iready", {15'h0, iready}, 16'h0);
        q.delete(); sent.delete();
        cur_v = 0; cur_b = 0; cur_l = 0; rx_n = 0;
        @(posedge clock);
        #1;
        chk("rst_hold_ovalid", {15'h0, ovalid}, 16'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_iready", {15'h0, iready}, 16'h1);
    endtask

    initial begin
        logic       pend, pd;
        logic [7:0] pw;
        int         max_run;
        do_reset();
        // Single word, LSB first.
        step(1, 0, 8'hD5);
        for (int i = 0; i < 7; i++) step(0, 0, 8'h00);
        chk("d5_lsb_seq", {8'h0, obs[7:0]}, 16'h00AB);
        for (int i = 0; i < FRAME - 7; i++) step(0, 0, 8'h00);
        chk("idle_after_frame", {15'h0, ovalid}, 16'h0);
        // Single word, MSB first.
        step(1, 1, 8'hD5);
        for (int i = 0; i < 7; i++) step(0, 0, 8'h00);
        chk("d5_msb_seq", {8'h0, obs[7:0]}, 16'h00D5);
        for (int i = 0; i < FRAME - 6; i++) step(0, 0, 8'h00);
        // Back-to-back: A5 then 3C with ivalid held high.
        max_run = 0;
        pend = 1;
        for (int c = 0; c < 2 * FRAME + 3; c++) begin
            if (c < FRAME) step(1, 0, 8'hA5);
            else if (c == FRAME) step(1, 1, 8'h3C);
            else step(0, 0, 8'h00);
            if (ov_cnt > max_run) max_run = ov_cnt;
        end
        chk("b2b_run", 16'(max_run), 16'(2 * FRAME));
        // Reset mid-frame at cycle 4, then a clean word.
        step(1, 0, 8'h5A);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00);
        do_reset();
        step(1, 1, 8'hC3);
        for (int i = 0; i < 7; i++) step(0, 0, 8'h00);
        chk("post_rst_word", {8'h0, obs[7:0]}, 16'h00C3);
        for (int i = 0; i < FRAME + 2; i++) step(0, 0, 8'h00);
`ifdef PAR2SER_PARITY_EN
        step(1, 0, 8'h07);
        for (int i = 0; i < 8; i++) step(0, 0, 8'h00);
        chk("parity_bit", {15'h0, odata}, 16'h1);
        chk("parity_last", {15'h0, olast}, 16'h1);
        step(0, 0, 8'h00);
`endif
        // Random traffic; upstream holds a word until it is accepted.
        pend = 0; pd = 0; pw = '0;
        for (int c = 0; c < 600; c++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1; pd = 1'($urandom_range(0, 1)); pw = 8'($urandom);
            end
            step(pend, pd, pw);
            if (pend && (!cur_v || cur_l || q.size() == FRAME - 1) && sent.size() > 0 && sent[$] == {pd, pw})
                pend = (q.size() != FRAME - 1);
        end
        for (int i = 0; i < FRAME + 2; i++) step(0, 0, 8'h00);
        chk("rx_all_drained", 16'(sent.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
